// File: rtl/canvas_buffer.sv
// canvas_buffer: paint canvas memory with a square brush stamper, full-canvas
// clear engine and a registered VGA read port with grid / out-of-canvas overlay.
module canvas_buffer #(
  parameter int                   CANVAS_W    = 128,
  parameter int                   CANVAS_H    = 128,
  parameter int                   COLOR_W     = 3,
  parameter int                   GRID_PITCH  = 50,
  parameter logic [COLOR_W-1:0]   OUT_COLOR   = '0,
  parameter logic [COLOR_W-1:0]   GRID_COLOR  = COLOR_W'(3'b101),
  parameter logic [COLOR_W-1:0]   CLEAR_COLOR = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        brush_valid,
  output logic                        brush_ready,
  input  logic [1:0]                  brush_size,
  input  logic [COLOR_W-1:0]          new_color,
  input  logic [$clog2(CANVAS_W)-1:0] wx,
  input  logic [$clog2(CANVAS_H)-1:0] wy,
  input  logic                        clear_req,
  output logic                        busy,
  input  logic [9:0]                  rx,
  input  logic [9:0]                  ry,
  output logic [COLOR_W-1:0]          color_code
);
  localparam int XW = $clog2(CANVAS_W);
  localparam int YW = $clog2(CANVAS_H);
  localparam int AW = XW + YW;
  localparam int N  = CANVAS_W * CANVAS_H;
  // keeps the modulo legal when the grid is disabled
  localparam int PITCH_SAFE = (GRID_PITCH == 0) ? 1 : GRID_PITCH;

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  state_t               state, state_nx;
  logic [AW-1:0]        clr_addr;
  logic                 clear_pending;
  logic [XW-1:0]        sx;
  logic [YW-1:0]        sy;
  logic [1:0]           ssize, cx, cy;
  logic [COLOR_W-1:0]   scolor;
  logic [COLOR_W-1:0]   mem [N];

  logic                 accept, stamp_last, clear_last, we;
  logic [AW-1:0]        waddr;
  logic [COLOR_W-1:0]   wdata;
  logic [XW:0]          px;
  logic [YW:0]          py;
  logic                 rd_out, rd_grid;
  logic [AW-1:0]        raddr;

  assign busy        = (state != IDLE);
  assign brush_ready = (state == IDLE) && !clear_req && !clear_pending;
  assign accept      = brush_valid && brush_ready;

  // one extra bit on the pixel coordinate flags stamps running off the canvas
  assign px         = {1'b0, sx} + (XW+1)'(cx);
  assign py         = {1'b0, sy} + (YW+1)'(cy);
  assign stamp_last = (cx == ssize) && (cy == ssize);
  assign clear_last = (clr_addr == AW'(N-1));

  assign rd_out  = ({1'b0, rx} >= 11'(CANVAS_W)) || ({1'b0, ry} >= 11'(CANVAS_H));
  assign rd_grid = (GRID_PITCH != 0) &&
                   (((rx % 10'(PITCH_SAFE)) == 10'd0) || ((ry % 10'(PITCH_SAFE)) == 10'd0));
  assign raddr   = {ry[YW-1:0], rx[XW-1:0]};

  // state register; reset parks the FSM in CLEAR so a full wipe follows release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nx;
  end

  // next state and memory write port
  always_comb begin
    state_nx = state;
    we       = 1'b0;
    waddr    = clr_addr;
    wdata    = CLEAR_COLOR;
    case (state)
      IDLE: begin
        if (clear_req)   state_nx = CLEAR;
        else if (accept) state_nx = STAMP;
      end
      STAMP: begin
        we    = !px[XW] && !py[YW];
        waddr = {py[YW-1:0], px[XW-1:0]};
        wdata = scolor;
        if (stamp_last) state_nx = (clear_pending || clear_req) ? CLEAR : IDLE;
      end
      CLEAR: begin
        we = 1'b1;
        if (clear_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // brush latch, stamp walk counters, clear address and deferred clear flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_addr      <= '0;
      clear_pending <= 1'b0;
      sx            <= '0;
      sy            <= '0;
      ssize         <= '0;
      scolor        <= '0;
      cx            <= '0;
      cy            <= '0;
    end else begin
      case (state)
        IDLE: begin
          clr_addr <= '0;
          cx       <= '0;
          cy       <= '0;
          if (accept) begin
            sx     <= wx;
            sy     <= wy;
            ssize  <= brush_size;
            scolor <= new_color;
          end
        end
        STAMP: begin
          if (clear_req) clear_pending <= 1'b1;
          if (cx == ssize) begin
            cx <= '0;
            cy <= cy + 2'd1;
          end else begin
            cx <= cx + 2'd1;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (clear_last) clear_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // canvas storage; writes held off while reset is low
  always_ff @(posedge clk) begin
    if (we && reset) mem[waddr] <= wdata;
  end

  // registered read: out-of-canvas beats grid beats stored pixel; old data on collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       color_code <= '0;
    else if (rd_out)  color_code <= OUT_COLOR;
    else if (rd_grid) color_code <= GRID_COLOR;
    else              color_code <= mem[raddr];
  end

endmodule

// File: tb/tb_canvas_buffer.sv
// tb_canvas_buffer: scoreboard bench for canvas_buffer (reads queued, popped one cycle later).
module tb_canvas_buffer;
  localparam int W = 128;
  localparam int H = 128;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       brush_valid = 1'b0;
  logic       clear_req = 1'b0;
  logic [1:0] brush_size = '0;
  logic [2:0] new_color = '0;
  logic [6:0] wx = '0;
  logic [6:0] wy = '0;
  logic [9:0] rx = '0;
  logic [9:0] ry = '0;
  logic       brush_ready, busy;
  logic [2:0] color_code;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] model [N];
  logic [2:0] sb_q [$];
  int         cnt, cnt2;

  canvas_buffer dut (
    .clk(clk), .reset(reset), .brush_valid(brush_valid), .brush_ready(brush_ready),
    .brush_size(brush_size), .new_color(new_color), .wx(wx), .wy(wy),
    .clear_req(clear_req), .busy(busy), .rx(rx), .ry(ry), .color_code(color_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_color(input int x, input int y);
    if (x >= W || y >= H) return 3'b000;
    if (x % 50 == 0 || y % 50 == 0) return 3'b101;
    return model[y*W + x];
  endfunction

  task automatic clear_model;
    for (int i = 0; i < N; i++) model[i] = 3'b000;
  endtask

  task automatic rd(input string tag, input int x, input int y);
    rx = 10'(x);
    ry = 10'(y);
    sb_q.push_back(exp_color(x, y));
    tick;
    chk(tag, color_code, sb_q.pop_front());
  endtask

  task automatic count_busy(output int c, input int limit);
    c = 0;
    while (busy && c < limit) begin
      tick;
      c++;
    end
  endtask

  task automatic stamp(input string tag, input int x, input int y, input int sz, input logic [2:0] c);
    int n;
    chk({tag, "_rdy"}, brush_ready, 1);
    wx = 7'(x); wy = 7'(y); brush_size = 2'(sz); new_color = c;
    brush_valid = 1'b1;
    tick;
    brush_valid = 1'b0;
    count_busy(n, 100);
    chk({tag, "_busy"}, n, (sz+1)*(sz+1));
    for (int dy = 0; dy <= sz; dy++)
      for (int dx = 0; dx <= sz; dx++)
        if (x+dx < W && y+dy < H) model[(y+dy)*W + x+dx] = c;
  endtask

  initial begin
    clear_model;
    // reset held
    tick; tick;
    chk("rst_busy", busy, 1);
    chk("rst_rdy", brush_ready, 0);
    chk("rst_color", color_code, 0);

    // release: automatic full clear
    reset = 1'b1;
    count_busy(cnt, N+100);
    chk("rst_clear_len", cnt, N);
    chk("rst_done_rdy", brush_ready, 1);
    rd("rd_10_10", 10, 10);

    // single-pixel stamp
    stamp("s0", 10, 20, 0, 3'b010);
    rd("rd_10_20", 10, 20);

    // edge stamp: no wrap-around
    stamp("s2", 126, 126, 2, 3'b110);
    rd("rd_126_126", 126, 126);
    rd("rd_127_126", 127, 126);
    rd("rd_126_127", 126, 127);
    rd("rd_127_127", 127, 127);
    rd("rd_0_0", 0, 0);
    rd("rd_0_126", 0, 126);
    rd("rd_1_126", 1, 126);
    rd("rd_1_127", 1, 127);
    rd("rd_1_1", 1, 1);

    // read priority, back-to-back
    stamp("s1", 51, 51, 1, 3'b011);
    rd("rd_grid_50_7", 50, 7);
    rd("rd_out_200_7", 200, 7);
    rd("rd_51_51", 51, 51);
    rd("rd_52_52", 52, 52);
    rd("rd_out_7_300", 7, 300);
    rd("rd_53_51", 53, 51);

    // read during write of the same pixel returns old data
    wx = 7'd60; wy = 7'd60; brush_size = 2'd0; new_color = 3'b111;
    brush_valid = 1'b1;
    tick;
    brush_valid = 1'b0;
    rx = 10'd60; ry = 10'd60;
    sb_q.push_back(3'b000);
    tick;
    chk("rw_old", color_code, sb_q.pop_front());
    chk("rw_idle", busy, 0);
    model[60*W + 60] = 3'b111;
    rd("rw_new", 60, 60);

    // clear wins over same-cycle brush
    wx = 7'd30; wy = 7'd30; brush_size = 2'd0; new_color = 3'b111;
    brush_valid = 1'b1; clear_req = 1'b1;
    #1;
    chk("clr_prio_rdy", brush_ready, 0);
    tick;
    brush_valid = 1'b0; clear_req = 1'b0;
    count_busy(cnt, N+100);
    chk("clr_len", cnt, N);
    clear_model;
    rd("clr_30_30", 30, 30);
    rd("clr_10_20", 10, 20);
    rd("clr_126_126", 126, 126);

    // clear during a size-3 stamp: stamp finishes, clear follows seamlessly
    wx = 7'd70; wy = 7'd70; brush_size = 2'd3; new_color = 3'b100;
    brush_valid = 1'b1;
    tick;
    brush_valid = 1'b0;
    tick; tick;
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    chk("pend_rdy", brush_ready, 0);
    count_busy(cnt2, N+100);
    chk("pend_total", 3 + cnt2, 16 + N);
    rd("pend_70_70", 70, 70);
    rd("pend_73_73", 73, 73);

    // reset mid-stamp abandons the stamp
    wx = 7'd20; wy = 7'd30; brush_size = 2'd3; new_color = 3'b110;
    brush_valid = 1'b1;
    tick;
    brush_valid = 1'b0;
    tick; tick;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_rdy", brush_ready, 0);
    chk("mid_rst_color", color_code, 0);
    tick;
    reset = 1'b1;
    count_busy(cnt, N+100);
    chk("mid_rst_clear_len", cnt, N);
    rd("mid_rst_20_30", 20, 30);
    rd("mid_rst_23_33", 23, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
